// File: rtl/matstore.sv
// Result-matrix writer: stores a rows/cols header and row-major FP32 elements to vmem.
// Optional MATSTORE_CANON_NAN_EN canonicalises NaN elements and adds a sticky nan_seen flag.
module matstore #(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_c,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              busy,
`ifdef MATSTORE_CANON_NAN_EN
  output logic              nan_seen,
`endif
  output logic              done
);

  localparam int TOT_W = 2 * DIM_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR_R = 3'd1,
    HDR_C = 3'd2,
    DATA  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  base_reg;
  logic [DIM_W-1:0]   rows_reg;
  logic [DIM_W-1:0]   cols_reg;
  logic [TOT_W-1:0]   total_reg;
  logic [TOT_W-1:0]   idx_reg;

  logic               start_acc;
  logic               data_fire;
  logic               last_elem;
  logic [ADDR_W-1:0]  data_addr;
  logic [31:0]        elem_wd;

  assign start_acc = (state_reg == IDLE) && start;
  assign data_fire = (state_reg == DATA) && in_valid;
  assign last_elem = (idx_reg == total_reg - TOT_W'(1));
  // Element address: base + 8 + 4*idx, wrapping silently at 2^ADDR_W.
  assign data_addr = base_reg + ADDR_W'(8) + (ADDR_W'(idx_reg) << 2);

`ifdef MATSTORE_CANON_NAN_EN
  logic in_is_nan;
  logic nan_seen_reg;

  assign in_is_nan = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
  assign elem_wd   = in_is_nan ? 32'h7FC0_0000 : in_data;
  assign nan_seen  = nan_seen_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nan_seen_reg <= 1'b0;
    end else if (start_acc) begin
      nan_seen_reg <= 1'b0;
    end else if (data_fire && in_is_nan) begin
      nan_seen_reg <= 1'b1;
    end
  end
`else
  assign elem_wd = in_data;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_reg  <= '0;
      rows_reg  <= '0;
      cols_reg  <= '0;
      total_reg <= '0;
      idx_reg   <= '0;
    end else if (start_acc) begin
      base_reg  <= addr_c;
      rows_reg  <= rows;
      cols_reg  <= cols;
      total_reg <= TOT_W'(rows) * TOT_W'(cols);
      idx_reg   <= '0;
    end else if (data_fire) begin
      idx_reg   <= idx_reg + TOT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = HDR_R;
      HDR_R:   state_next = HDR_C;
      HDR_C:   state_next = (total_reg == '0) ? DONE : DATA;
      DATA:    if (in_valid && last_elem) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory port is combinational so each write lands on the edge closing its cycle.
  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    busy     = (state_reg != IDLE);
    done     = 1'b0;
    case (state_reg)
      HDR_R: begin
        mem_we   = 1'b1;
        mem_addr = base_reg;
        mem_wd   = 32'(rows_reg);
      end
      HDR_C: begin
        mem_we   = 1'b1;
        mem_addr = base_reg + ADDR_W'(4);
        mem_wd   = 32'(cols_reg);
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we   = 1'b1;
          mem_addr = data_addr;
          mem_wd   = elem_wd;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_matstore.sv
// Directed self-checking bench for matstore: header/data writes, stalls, empty matrix,
// ignored out-of-state inputs, asynchronous reset and (optionally) NaN canonicalisation.
module tb_matstore;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] addr_c;
  logic [15:0] rows;
  logic [15:0] cols;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        busy;
  logic        done;
`ifdef MATSTORE_CANON_NAN_EN
  logic        nan_seen;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  logic hit_200 = 1'b0;
  logic [31:0] din [0:7];

  always #5 clk = ~clk;

  matstore #(.ADDR_W(32), .DIM_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .addr_c   (addr_c),
    .rows     (rows),
    .cols     (cols),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .busy     (busy),
`ifdef MATSTORE_CANON_NAN_EN
    .nan_seen (nan_seen),
`endif
    .done     (done)
  );

  // Memory-side observer: counts every write and flags any write to 0x200.
  always @(posedge clk) begin
    if (mem_we) begin
      wr_cnt <= wr_cnt + 1;
      if (mem_addr == 32'h200) hit_200 <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_wd(input logic [31:0] d);
`ifdef MATSTORE_CANON_NAN_EN
    if (d[30:23] == 8'hFF && d[22:0] != 23'd0) return 32'h7FC0_0000;
`endif
    return d;
  endfunction

  task automatic set_elems(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                           input logic [31:0] a3, input logic [31:0] a4, input logic [31:0] a5);
    din[0] = a0; din[1] = a1; din[2] = a2; din[3] = a3; din[4] = a4; din[5] = a5;
    din[6] = 32'h0; din[7] = 32'h0;
  endtask

  // One full transfer. stall_at: element index before which in_valid drops for stall_len cycles.
  task automatic run(input logic [31:0] base, input int r, input int c, input int stall_at,
                     input int stall_len, input bit poke_start, input bit early_valid);
    int total;
    int i;
    int stalled;
    int cyc;
    int w0;
    bit v;
    total = r * c;
    i = 0;
    stalled = 0;
    cyc = 0;
    @(posedge clk); #1;
    start = 1'b1; addr_c = base; rows = 16'(r); cols = 16'(c);
    w0 = wr_cnt;
    @(negedge clk);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_we", {63'd0, mem_we}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; addr_c = 32'h0; rows = 16'd0; cols = 16'd0;
    if (early_valid) begin in_valid = 1'b1; in_data = din[0]; end
    @(negedge clk);
    check("hdr0_we", {63'd0, mem_we}, 64'd1);
    check("hdr0_addr", {32'd0, mem_addr}, {32'd0, base});
    check("hdr0_wd", {32'd0, mem_wd}, 64'(r));
    check("hdr0_busy", {63'd0, busy}, 64'd1);
    check("hdr0_rdy", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("hdr1_we", {63'd0, mem_we}, 64'd1);
    check("hdr1_addr", {32'd0, mem_addr}, {32'd0, base + 32'd4});
    check("hdr1_wd", {32'd0, mem_wd}, 64'(c));
    check("hdr1_rdy", {63'd0, in_ready}, 64'd0);
    while (i < total && cyc < 200) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (stall_at == i && stalled < stall_len) begin
        v = 1'b0; stalled++;
      end else begin
        v = 1'b1;
      end
      in_valid = v;
      in_data = v ? din[i] : 32'hDEAD_BEEF;
      if (poke_start && i == 1) begin start = 1'b1; addr_c = 32'h200; end
      @(negedge clk);
      check("data_rdy", {63'd0, in_ready}, 64'd1);
      check("data_we", {63'd0, mem_we}, {63'd0, v});
      if (v) begin
        check("data_addr", {32'd0, mem_addr}, {32'd0, base + 32'd8 + 32'(4 * i)});
        check("data_wd", {32'd0, mem_wd}, {32'd0, exp_wd(din[i])});
        i++;
      end
      check("data_done", {63'd0, done}, 64'd0);
      cyc++;
    end
    if (cyc >= 200) check("data_timeout", 64'(cyc), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; addr_c = 32'h0;
    in_valid = 1'b1; in_data = 32'h1234_5678;
    @(negedge clk);
    check("done_hi", {63'd0, done}, 64'd1);
    check("done_rdy", {63'd0, in_ready}, 64'd0);
    check("done_we", {63'd0, mem_we}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("after_done", {63'd0, done}, 64'd0);
    check("after_busy", {63'd0, busy}, 64'd0);
    check("wr_count", 64'(wr_cnt - w0), 64'(2 + total));
    $display("transfer base=%0h rows=%0d cols=%0d stall=%0d writes=%0d", base, r, c,
             stall_len, wr_cnt - w0);
  endtask

  initial begin
    int w_snap;
    reset = 1'b0; start = 1'b0; addr_c = 32'h0; rows = 16'd0; cols = 16'd0;
    in_valid = 1'b0; in_data = 32'h0;
    set_elems(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
              32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000);
    #12;
    check("rst_rdy", {63'd0, in_ready}, 64'd0);
    check("rst_we", {63'd0, mem_we}, 64'd0);
    check("rst_addr", {32'd0, mem_addr}, 64'd0);
    check("rst_wd", {32'd0, mem_wd}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    run(32'h100, 2, 3, -1, 0, 1'b0, 1'b0);
    run(32'h100, 2, 3, 2, 2, 1'b0, 1'b0);
    run(32'h400, 0, 5, -1, 0, 1'b0, 1'b0);
    run(32'h500, 2, 3, -1, 0, 1'b1, 1'b1);
    check("no_write_200", {63'd0, hit_200}, 64'd0);
    run(32'hFFFF_FFF8, 1, 2, -1, 0, 1'b0, 1'b0);

    // Reset mid-transfer after 3 of 6 elements.
    @(posedge clk); #1;
    start = 1'b1; addr_c = 32'h180; rows = 16'd2; cols = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = din[k];
    end
    @(posedge clk); #1;
    in_data = din[3];
    w_snap = wr_cnt;
    reset = 1'b0;
    #1;
    check("arst_we", {63'd0, mem_we}, 64'd0);
    check("arst_addr", {32'd0, mem_addr}, 64'd0);
    check("arst_wd", {32'd0, mem_wd}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_rdy", {63'd0, in_ready}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("arst_nowrite", 64'(wr_cnt - w_snap), 64'd0);
    in_valid = 1'b0;
    reset = 1'b1;
    $display("reset mid-transfer base=180 writes_after_reset=%0d", wr_cnt - w_snap);
    run(32'h300, 2, 3, -1, 0, 1'b0, 1'b0);

`ifdef MATSTORE_CANON_NAN_EN
    set_elems(32'h7F80_0001, 32'h7F80_0000, 32'h0, 32'h0, 32'h0, 32'h0);
    check("nan_pre", {63'd0, nan_seen}, 64'd0);
    run(32'h600, 1, 2, -1, 0, 1'b0, 1'b0);
    check("nan_seen", {63'd0, nan_seen}, 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
